// File: rtl/cpu_core_mc_if.sv
// Memory-side bus of cpu_core_mc: synchronous instruction and data memories,
// read data returned one clock after the address.
interface cpu_core_mc_if #(
    parameter int D  = 10,
    parameter int W  = 8,
    parameter int IW = 9
);
    logic [D-1:0]  imem_addr;
    logic [IW-1:0] imem_rdata;
    logic [W-1:0]  dmem_addr;
    logic          dmem_we;
    logic [W-1:0]  dmem_wdata;
    logic [W-1:0]  dmem_rdata;

    modport master (
        output imem_addr,
        input  imem_rdata,
        output dmem_addr,
        output dmem_we,
        output dmem_wdata,
        input  dmem_rdata
    );

    modport slave (
        input  imem_addr,
        output imem_rdata,
        input  dmem_addr,
        input  dmem_we,
        input  dmem_wdata,
        output dmem_rdata
    );
endinterface

// File: rtl/cpu_core_mc.sv
// Multi-cycle accumulator-style CPU: FETCH/EXEC(/MEM) per instruction,
// start/busy/done handshake, HALT, programmable end address, cycle counter.
module cpu_core_mc #(
    parameter int D  = 10,
    parameter int W  = 8,
    parameter int PW = 3,
    parameter int CW = 16
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          start,
    input  logic [D-1:0]  start_addr,
    input  logic [D-1:0]  end_addr,
    output logic          busy,
    output logic          done,
    output logic [CW-1:0] cycle_count,
    cpu_core_mc_if.master bus
);
    localparam int IW = 3 + 2 * PW;
    localparam int NR = 2 ** PW;

    localparam logic [2:0] OP_XOR  = 3'd0;
    localparam logic [2:0] OP_BEQ  = 3'd1;
    localparam logic [2:0] OP_ADDI = 3'd2;
    localparam logic [2:0] OP_ANDI = 3'd3;
    localparam logic [2:0] OP_LSL  = 3'd4;
    localparam logic [2:0] OP_LD   = 3'd5;
    localparam logic [2:0] OP_ST   = 3'd6;
    localparam logic [2:0] OP_J    = 3'd7;

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_EXEC,
        S_MEM,
        S_DONE
    } state_t;

    state_t        r_state;
    state_t        w_state_next;
    logic [D-1:0]  r_pc;
    logic [D-1:0]  w_pc_next;
    logic [CW-1:0] r_cc;
    logic          w_cc_clear;
    logic [PW-1:0] r_ld_dst;
    logic [W-1:0]  r_regs [NR];

    logic [2:0]      w_op;
    logic [PW-1:0]   w_a;
    logic [PW-1:0]   w_b;
    logic [2*PW-1:0] w_off;
    logic [W-1:0]    w_ra;
    logic [W-1:0]    w_rb;
    logic [W-1:0]    w_shl;
    logic            w_running;

    logic          w_wr_en;
    logic [PW-1:0] w_wr_idx;
    logic [W-1:0]  w_wr_data;
    logic [W-1:0]  w_mem_addr;
    logic          w_mem_we;
    logic [W-1:0]  w_mem_wdata;

    assign w_op  = bus.imem_rdata[IW-1 -: 3];
    assign w_a   = bus.imem_rdata[2*PW-1:PW];
    assign w_b   = bus.imem_rdata[PW-1:0];
    assign w_off = bus.imem_rdata[2*PW-1:0];
    assign w_ra  = r_regs[w_a];
    assign w_rb  = r_regs[w_b];
    assign w_shl = (32'(w_b) >= W) ? '0 : (w_ra << w_b);

    assign w_running = (r_state == S_FETCH) || (r_state == S_EXEC) || (r_state == S_MEM);

    always_comb begin
        w_state_next = r_state;
        w_pc_next    = r_pc;
        w_cc_clear   = 1'b0;
        w_wr_en      = 1'b0;
        w_wr_idx     = w_a;
        w_wr_data    = '0;
        w_mem_addr   = '0;
        w_mem_we     = 1'b0;
        w_mem_wdata  = '0;
        case (r_state)
            S_IDLE, S_DONE: begin
                if (start) begin
                    w_state_next = S_FETCH;
                    w_pc_next    = start_addr;
                    w_cc_clear   = 1'b1;
                end
            end
            S_FETCH: begin
                w_state_next = (r_pc == end_addr) ? S_DONE : S_EXEC;
            end
            S_EXEC: begin
                w_state_next = S_FETCH;
                w_pc_next    = r_pc + D'(1);
                case (w_op)
                    OP_XOR: begin
                        w_wr_en   = 1'b1;
                        w_wr_data = w_ra ^ w_rb;
                    end
                    OP_BEQ: begin
                        if (w_ra == r_regs[0]) w_pc_next = r_pc + D'($signed(w_b));
                    end
                    OP_ADDI: begin
                        w_wr_en   = 1'b1;
                        w_wr_data = w_ra + W'($signed(w_b));
                    end
                    OP_ANDI: begin
                        w_wr_en   = 1'b1;
                        w_wr_data = w_ra & W'(w_b);
                    end
                    OP_LSL: begin
                        w_wr_en   = 1'b1;
                        w_wr_data = w_shl;
                    end
                    OP_LD: begin
                        // pc advances in MEM once the load data has landed
                        w_mem_addr   = w_rb;
                        w_pc_next    = r_pc;
                        w_state_next = S_MEM;
                    end
                    OP_ST: begin
                        w_mem_addr  = w_rb;
                        w_mem_wdata = w_ra;
                        w_mem_we    = 1'b1;
                    end
                    default: begin
                        if (w_off == '0) begin
                            w_pc_next    = r_pc;
                            w_state_next = S_DONE;
                        end else begin
                            w_pc_next = r_pc + D'($signed(w_off));
                        end
                    end
                endcase
            end
            S_MEM: begin
                w_wr_en      = 1'b1;
                w_wr_idx     = r_ld_dst;
                w_wr_data    = bus.dmem_rdata;
                w_pc_next    = r_pc + D'(1);
                w_state_next = S_FETCH;
            end
            default: w_state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state  <= S_IDLE;
            r_pc     <= '0;
            r_cc     <= '0;
            r_ld_dst <= '0;
        end else begin
            r_state <= w_state_next;
            r_pc    <= w_pc_next;
            if (w_cc_clear) r_cc <= '0;
            else if (w_running && (r_cc != {CW{1'b1}})) r_cc <= r_cc + CW'(1);
            if (r_state == S_EXEC) r_ld_dst <= w_a;
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < NR; gi++) begin : g_regs
            always_ff @(posedge clk) begin
                if (!reset) r_regs[gi] <= '0;
                else if (w_wr_en && (w_wr_idx == PW'(gi))) r_regs[gi] <= w_wr_data;
            end
        end
    endgenerate

    // Outputs are forced to idle values while reset is low so an aborted ST never strobes.
    assign bus.imem_addr  = reset ? r_pc : '0;
    assign bus.dmem_addr  = reset ? w_mem_addr : '0;
    assign bus.dmem_we    = reset & w_mem_we;
    assign bus.dmem_wdata = reset ? w_mem_wdata : '0;
    assign busy           = reset & w_running;
    assign done           = reset & (r_state == S_DONE);
    assign cycle_count    = reset ? r_cc : '0;
endmodule

// File: tb/tb_cpu_core_mc.sv
// Directed bench for cpu_core_mc: programs in a shared instruction memory,
// data-memory model with write log, and a CW=4 instance for saturation.
module tb_cpu_core_mc;
    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        start = 1'b0;
    logic        start_s = 1'b0;
    logic [9:0]  start_addr = '0;
    logic [9:0]  end_addr = '0;
    logic        busy, done, busy_s, done_s;
    logic [15:0] cycle_count;
    logic [3:0]  cycle_count_s;

    logic [8:0]  imem [0:1023];
    logic [7:0]  dmem [0:255];
    logic        pre_we = 1'b0;
    logic [7:0]  pre_addr = '0;
    logic [7:0]  pre_data = '0;
    int          we_count = 0;
    logic [7:0]  last_waddr = '0;
    logic [7:0]  last_wdata = '0;

    int n_cmp = 0;
    int n_bad = 0;

    cpu_core_mc_if #(.D(10), .W(8), .IW(9)) bus ();
    cpu_core_mc_if #(.D(10), .W(8), .IW(9)) bus_s ();

    cpu_core_mc #(.D(10), .W(8), .PW(3), .CW(16)) dut (
        .clk(clk), .reset(reset), .start(start), .start_addr(start_addr), .end_addr(end_addr),
        .busy(busy), .done(done), .cycle_count(cycle_count), .bus(bus)
    );

    cpu_core_mc #(.D(10), .W(8), .PW(3), .CW(4)) dut_sat (
        .clk(clk), .reset(reset), .start(start_s), .start_addr(start_addr), .end_addr(end_addr),
        .busy(busy_s), .done(done_s), .cycle_count(cycle_count_s), .bus(bus_s)
    );

    always #5 clk = ~clk;

    always @(posedge clk) bus.imem_rdata <= imem[bus.imem_addr];
    always @(posedge clk) bus_s.imem_rdata <= imem[bus_s.imem_addr];
    assign bus_s.dmem_rdata = '0;

    always @(posedge clk) begin
        if (pre_we) begin
            dmem[pre_addr] <= pre_data;
        end else if (bus.dmem_we) begin
            dmem[bus.dmem_addr] <= bus.dmem_wdata;
            we_count   <= we_count + 1;
            last_waddr <= bus.dmem_addr;
            last_wdata <= bus.dmem_wdata;
        end
        bus.dmem_rdata <= dmem[bus.dmem_addr];
    end

    function automatic logic [8:0] enc(input int op, input int a, input int b);
        return {op[2:0], a[2:0], b[2:0]};
    endfunction

    function automatic logic [8:0] encj(input int off);
        return {3'b111, off[5:0]};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic kick(input logic [9:0] sa, input logic [9:0] ea);
        start_addr = sa;
        end_addr   = ea;
        start      = 1'b1;
        tick();
        start      = 1'b0;
    endtask

    task automatic wait_done(input int budget);
        for (int i = 0; i < budget; i++) begin
            if (done) break;
            tick();
        end
    endtask

    task automatic test_reset();
        reset = 1'b0;
        tick();
        tick();
        n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL reset_busy: got %b want 0", busy); end
        n_cmp++; if (done !== 1'b0) begin n_bad++; $display("FAIL reset_done: got %b want 0", done); end
        n_cmp++; if (cycle_count !== 16'd0) begin n_bad++; $display("FAIL reset_cc: got %0d want 0", cycle_count); end
        n_cmp++; if (bus.imem_addr !== 10'd0) begin n_bad++; $display("FAIL reset_imem_addr: got %h want 0", bus.imem_addr); end
        n_cmp++; if (bus.dmem_we !== 1'b0) begin n_bad++; $display("FAIL reset_dmem_we: got %b want 0", bus.dmem_we); end
        reset = 1'b1;
        tick();
        $display("test_reset: busy=%b done=%b cc=%0d", busy, done, cycle_count);
    endtask

    task automatic test_idle_end();
        kick(10'd0, 10'd0);
        n_cmp++; if (busy !== 1'b1) begin n_bad++; $display("FAIL idle_busy_fetch: got %b want 1", busy); end
        n_cmp++; if (done !== 1'b0) begin n_bad++; $display("FAIL idle_done_fetch: got %b want 0", done); end
        tick();
        n_cmp++; if (done !== 1'b1) begin n_bad++; $display("FAIL idle_done: got %b want 1", done); end
        n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL idle_busy_done: got %b want 0", busy); end
        n_cmp++; if (cycle_count !== 16'd1) begin n_bad++; $display("FAIL idle_cc: got %0d want 1", cycle_count); end
        n_cmp++; if (we_count !== 0) begin n_bad++; $display("FAIL idle_we_count: got %0d want 0", we_count); end
        $display("test_idle_end: done=%b cc=%0d", done, cycle_count);
    endtask

    task automatic test_alu();
        kick(10'd0, 10'd4);
        wait_done(100);
        n_cmp++; if (done !== 1'b1) begin n_bad++; $display("FAIL alu_done: got %b want 1", done); end
        n_cmp++; if (dut.r_regs[1] !== 8'd4) begin n_bad++; $display("FAIL alu_r1: got %h want 04", dut.r_regs[1]); end
        n_cmp++; if (dut.r_regs[2] !== 8'd4) begin n_bad++; $display("FAIL alu_r2: got %h want 04", dut.r_regs[2]); end
        n_cmp++; if (cycle_count !== 16'd9) begin n_bad++; $display("FAIL alu_cc: got %0d want 9", cycle_count); end
        $display("test_alu: r1=%h r2=%h cc=%0d", dut.r_regs[1], dut.r_regs[2], cycle_count);
    endtask

    task automatic test_branch();
        kick(10'd8, 10'd13);
        wait_done(200);
        n_cmp++; if (done !== 1'b1) begin n_bad++; $display("FAIL br_done: got %b want 1", done); end
        n_cmp++; if (dut.r_regs[1] !== 8'd0) begin n_bad++; $display("FAIL br_r1: got %h want 00", dut.r_regs[1]); end
        n_cmp++; if (cycle_count !== 16'd15) begin n_bad++; $display("FAIL br_cc: got %0d want 15", cycle_count); end
        n_cmp++; if (bus.imem_addr !== 10'd13) begin n_bad++; $display("FAIL br_pc: got %0d want 13", bus.imem_addr); end
        $display("test_branch: r1=%h pc=%0d cc=%0d", dut.r_regs[1], bus.imem_addr, cycle_count);
    endtask

    task automatic test_memory();
        pre_we = 1'b1; pre_addr = 8'd0; pre_data = 8'hA5;
        tick();
        pre_we = 1'b0;
        kick(10'd16, 10'd21);
        wait_done(200);
        n_cmp++; if (done !== 1'b1) begin n_bad++; $display("FAIL mem_done: got %b want 1", done); end
        n_cmp++; if (we_count !== 1) begin n_bad++; $display("FAIL mem_we_pulses: got %0d want 1", we_count); end
        n_cmp++; if (last_waddr !== 8'd5) begin n_bad++; $display("FAIL mem_waddr: got %h want 05", last_waddr); end
        n_cmp++; if (last_wdata !== 8'hA5) begin n_bad++; $display("FAIL mem_wdata: got %h want a5", last_wdata); end
        n_cmp++; if (dmem[5] !== 8'hA5) begin n_bad++; $display("FAIL mem_cell5: got %h want a5", dmem[5]); end
        n_cmp++; if (dut.r_regs[2] !== 8'hA5) begin n_bad++; $display("FAIL mem_ld_r2: got %h want a5", dut.r_regs[2]); end
        n_cmp++; if (cycle_count !== 16'd13) begin n_bad++; $display("FAIL mem_cc: got %0d want 13", cycle_count); end
        $display("test_memory: we=%0d addr=%h data=%h r2=%h cc=%0d", we_count, last_waddr, last_wdata, dut.r_regs[2], cycle_count);
    endtask

    task automatic test_halt();
        kick(10'd7, 10'd100);
        wait_done(50);
        n_cmp++; if (done !== 1'b1) begin n_bad++; $display("FAIL halt_done: got %b want 1", done); end
        n_cmp++; if (bus.imem_addr !== 10'd7) begin n_bad++; $display("FAIL halt_pc: got %0d want 7", bus.imem_addr); end
        n_cmp++; if (cycle_count !== 16'd2) begin n_bad++; $display("FAIL halt_cc: got %0d want 2", cycle_count); end
        n_cmp++; if (dut.r_regs[1] !== 8'hA5) begin n_bad++; $display("FAIL halt_r1: got %h want a5", dut.r_regs[1]); end
        kick(10'd0, 10'd0);
        n_cmp++; if (done !== 1'b0) begin n_bad++; $display("FAIL restart_done: got %b want 0", done); end
        n_cmp++; if (busy !== 1'b1) begin n_bad++; $display("FAIL restart_busy: got %b want 1", busy); end
        n_cmp++; if (bus.imem_addr !== 10'd0) begin n_bad++; $display("FAIL restart_pc: got %0d want 0", bus.imem_addr); end
        wait_done(10);
        $display("test_halt: restarted pc=%0d done=%b", bus.imem_addr, done);
    endtask

    task automatic test_wrap();
        kick(10'd24, 10'd25);
        wait_done(20);
        n_cmp++; if (dut.r_regs[0] !== 8'hFF) begin n_bad++; $display("FAIL wrap_r0: got %h want ff", dut.r_regs[0]); end
        n_cmp++; if (cycle_count !== 16'd3) begin n_bad++; $display("FAIL wrap_cc: got %0d want 3", cycle_count); end
        $display("test_wrap: r0=%h", dut.r_regs[0]);
    endtask

    task automatic test_reset_mid_run();
        kick(10'd30, 10'd31);
        tick();
        n_cmp++; if (bus.dmem_we !== 1'b1) begin n_bad++; $display("FAIL mid_st_strobe: got %b want 1", bus.dmem_we); end
        reset = 1'b0;
        #1;
        n_cmp++; if (bus.dmem_we !== 1'b0) begin n_bad++; $display("FAIL mid_we_gated: got %b want 0", bus.dmem_we); end
        n_cmp++; if (bus.dmem_wdata !== 8'd0) begin n_bad++; $display("FAIL mid_wdata: got %h want 00", bus.dmem_wdata); end
        n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL mid_busy: got %b want 0", busy); end
        n_cmp++; if (cycle_count !== 16'd0) begin n_bad++; $display("FAIL mid_cc: got %0d want 0", cycle_count); end
        tick();
        reset = 1'b1;
        #1;
        n_cmp++; if (we_count !== 1) begin n_bad++; $display("FAIL mid_no_write: got %0d want 1", we_count); end
        n_cmp++; if (dmem[5] !== 8'hA5) begin n_bad++; $display("FAIL mid_cell5: got %h want a5", dmem[5]); end
        n_cmp++; if (dut.r_regs[0] !== 8'd0) begin n_bad++; $display("FAIL mid_r0_cleared: got %h want 00", dut.r_regs[0]); end
        n_cmp++; if (done !== 1'b0 || busy !== 1'b0) begin n_bad++; $display("FAIL mid_idle: got busy=%b done=%b want 0/0", busy, done); end
        n_cmp++; if (bus.imem_addr !== 10'd0) begin n_bad++; $display("FAIL mid_pc: got %0d want 0", bus.imem_addr); end
        $display("test_reset_mid_run: we=%0d busy=%b done=%b", we_count, busy, done);
    endtask

    task automatic test_saturation();
        start_addr = 10'd40;
        end_addr   = 10'd43;
        start_s    = 1'b1;
        tick();
        start_s    = 1'b0;
        for (int i = 0; i < 5; i++) tick();
        n_cmp++; if (cycle_count_s !== 4'd5) begin n_bad++; $display("FAIL sat_cc_mid: got %0d want 5", cycle_count_s); end
        for (int i = 0; i < 4000; i++) begin
            if (done_s) break;
            tick();
        end
        n_cmp++; if (done_s !== 1'b1) begin n_bad++; $display("FAIL sat_done: got %b want 1", done_s); end
        n_cmp++; if (cycle_count_s !== 4'd15) begin n_bad++; $display("FAIL sat_cc: got %0d want 15", cycle_count_s); end
        $display("test_saturation: done=%b cc=%0d", done_s, cycle_count_s);
    endtask

    initial begin
        for (int i = 0; i < 1024; i++) imem[i] = encj(0);
        imem[0]  = enc(2, 1, 3);
        imem[1]  = enc(4, 1, 2);
        imem[2]  = enc(3, 1, 7);
        imem[3]  = enc(0, 2, 1);
        imem[7]  = encj(0);
        imem[8]  = enc(3, 1, 0);
        imem[9]  = enc(2, 1, 2);
        imem[10] = enc(2, 1, -1);
        imem[11] = enc(1, 1, 2);
        imem[12] = encj(-2);
        imem[16] = enc(5, 1, 0);
        imem[17] = enc(2, 3, 3);
        imem[18] = enc(2, 3, 2);
        imem[19] = enc(6, 1, 3);
        imem[20] = enc(5, 2, 3);
        imem[24] = enc(2, 0, -1);
        imem[30] = enc(6, 0, 3);
        imem[40] = enc(2, 1, -1);
        imem[41] = enc(1, 1, 2);
        imem[42] = encj(-2);

        test_reset();
        test_idle_end();
        test_alu();
        test_branch();
        test_memory();
        test_halt();
        test_wrap();
        test_reset_mid_run();
        test_saturation();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
